// File: rtl/code_conv_pkg.sv
// rtl/code_conv_pkg.sv - shared types, widths and forward code map for the code inverse scanner
// Contents:
//   state_t  scanner FSM states (IDLE, SCAN, EMIT, NONE)
//   CODE_W   code/data width
//   NUM_X    number of source values scanned (1 << CODE_W)
//   f_fwd    forward 4-bit code converter y = f(x)
package code_conv_pkg;

  localparam int CODE_W = 4;
  localparam int NUM_X  = 1 << CODE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    NONE = 2'd3
  } state_t;

  function automatic logic [CODE_W-1:0] f_fwd(input logic [CODE_W-1:0] x);
    logic [CODE_W-1:0] y;
    case (x)
      4'd0:    y = 4'd2;
      4'd1:    y = 4'd3;
      4'd2:    y = 4'd8;
      4'd3:    y = 4'd0;
      4'd4:    y = 4'd3;
      4'd5:    y = 4'd11;
      4'd6:    y = 4'd10;
      4'd7:    y = 4'd13;
      4'd8:    y = 4'd9;
      4'd9:    y = 4'd15;
      4'd10:   y = 4'd12;
      4'd11:   y = 4'd7;
      4'd12:   y = 4'd1;
      4'd13:   y = 4'd2;
      4'd14:   y = 4'd1;
      default: y = 4'd4;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/code_fwd_map.sv
// rtl/code_fwd_map.sv - combinational forward code map x -> y
// Ports:
//   x  in   CODE_W  source value
//   y  out  CODE_W  converted code f(x)
module code_fwd_map
  import code_conv_pkg::*;
(
  input  logic [CODE_W-1:0] x,
  output logic [CODE_W-1:0] y
);

  assign y = f_fwd(x);

endmodule

// File: rtl/code_inverse_scanner.sv
// rtl/code_inverse_scanner.sv - streams every x with f(x)==code, ascending, over valid/ready
// Optional feature: MATCH_CNT_EN (registered preimage count on the last beat).
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       request accepted when high (IDLE only)
//   req_code   in   N_BITS  code to invert
//   out_valid  out  1       result beat present
//   out_ready  in   1       sink accepts beat
//   out_data   out  N_BITS  matching x (0 on a none beat)
//   out_last   out  1       final beat of this request
//   out_none   out  1       code has no preimage
//   match_cnt  out  2       preimage count during the last beat (0 unless MATCH_CNT_EN)
module code_inverse_scanner
  import code_conv_pkg::*;
#(
  parameter int N_BITS = CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_BITS-1:0] req_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_last,
  output logic              out_none,
  output logic [1:0]        match_cnt
);

  if (N_BITS != CODE_W) begin : g_bad_width
    $error("code_inverse_scanner: N_BITS must be 4");
  end

  state_t             state_r, state_n;
  logic [NUM_X-1:0]   mask_w, mask_r, mask_n;
  logic [CODE_W-1:0]  idx_r, idx_n;
  logic               last_r, last_n;
  logic [CODE_W:0]    shamt;
  logic [NUM_X-1:0]   rest;
  logic               accept;

  // One forward map per candidate x; the mask marks every x that lands on req_code.
  for (genvar i = 0; i < NUM_X; i++) begin : g_map
    logic [CODE_W-1:0] y;
    code_fwd_map u_map (
      .x (CODE_W'(i)),
      .y (y)
    );
    assign mask_w[i] = (y == req_code);
  end

  assign accept = req_valid && (state_r == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mask_r  <= '0;
      idx_r   <= '0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      mask_r  <= mask_n;
      idx_r   <= idx_n;
      last_r  <= last_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    mask_n    = mask_r;
    idx_n     = idx_r;
    last_n    = last_r;
    req_ready = (state_r == IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    // Bits above idx; a 5-bit shift amount keeps idx=15 from wrapping to a shift of 0.
    shamt     = {1'b0, idx_r} + 5'd1;
    rest      = mask_r >> shamt;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          mask_n  = mask_w;
          idx_n   = '0;
          last_n  = 1'b0;
          state_n = (mask_w == '0) ? NONE : SCAN;
        end
      end
      SCAN: begin
        if (mask_r[idx_r]) begin
          last_n  = (rest == '0);
          state_n = EMIT;
        end else begin
          idx_n = idx_r + 1'b1;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = idx_r;
        out_last  = last_r;
        if (out_ready) begin
          if (last_r) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx_r + 1'b1;
            state_n = SCAN;
          end
        end
      end
      NONE: begin
        out_valid = 1'b1;
        out_none  = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef MATCH_CNT_EN
  logic [1:0] cnt_r;

  // At most two preimages exist, so a 2-bit count holds every case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (accept) begin
      cnt_r <= 2'($countones(mask_w));
    end
  end

  assign match_cnt = (out_valid && out_last) ? cnt_r : 2'd0;
`else
  assign match_cnt = 2'd0;
`endif

endmodule
